// File: rtl/ce_debounce.sv
// ce_debounce: clock-enable driven button debouncer.
// A raw asynchronous button level is synchronized on every clock, then
// qualified only on CE strobes: a new level must be seen on N_STABLE
// consecutive strobes before it is accepted. The block produces the
// debounced level, single-cycle rise/fall strobes and an auto-repeat
// strobe while the button stays pressed. All outputs are registered.
module ce_debounce #(
    parameter int N_STABLE   = 20,
    parameter int REPEAT_DLY = 500,
    parameter int REPEAT_PER = 100,
    parameter int CNT_W      = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic ce,
    input  logic btn_in,
    output logic btn_out,
    output logic btn_rise,
    output logic btn_fall,
    output logic btn_rep
);

    // Debounce states: BTN_OUT is 0 in LOW/W_HIGH and 1 in HIGH/W_LOW.
    typedef enum logic [1:0] {
        ST_LOW    = 2'd0,
        ST_W_HIGH = 2'd1,
        ST_HIGH   = 2'd2,
        ST_W_LOW  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] N_STABLE_C   = CNT_W'(N_STABLE);
    localparam logic [CNT_W-1:0] REPEAT_DLY_C = CNT_W'(REPEAT_DLY);
    localparam logic [CNT_W-1:0] REPEAT_PER_C = CNT_W'(REPEAT_PER);
    // A single qualifying sample is enough: skip the waiting states.
    localparam bit               SINGLE_C     = (N_STABLE == 1);
    // A zero initial delay turns auto-repeat off entirely.
    localparam bit               REP_EN_C     = (REPEAT_DLY != 0);

    // Synchronizer stages.
    logic             sync_1_r;
    logic             sync_2_r;

    // FSM and counters.
    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic [CNT_W-1:0] rep_cnt_r;
    logic [CNT_W-1:0] rep_cnt_s;
    logic             rep_armed_r;
    logic             rep_armed_s;

    // Registered outputs.
    logic             btn_out_r;
    logic             btn_out_s;
    logic             rise_r;
    logic             rise_s;
    logic             fall_r;
    logic             fall_s;
    logic             rep_r;
    logic             rep_s;

    // Helper terms.
    logic             held_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic             stable_hit_s;
    logic [CNT_W-1:0] rep_cnt_inc_s;
    logic [CNT_W-1:0] rep_target_s;
    logic             rep_hit_s;

    // The button is considered held for auto-repeat in HIGH and W_LOW.
    assign held_s        = (state_r == ST_HIGH) || (state_r == ST_W_LOW);
    assign cnt_inc_s     = cnt_r + CNT_W'(1);
    assign stable_hit_s  = (cnt_inc_s == N_STABLE_C);
    // With auto-repeat disabled the repeat counter is pinned at zero.
    assign rep_cnt_inc_s = REP_EN_C ? (rep_cnt_r + CNT_W'(1)) : CNT_W'(0);
    // First pulse waits REPEAT_DLY ticks, later pulses REPEAT_PER ticks.
    assign rep_target_s  = rep_armed_r ? REPEAT_PER_C : REPEAT_DLY_C;
    assign rep_hit_s     = REP_EN_C && held_s && (rep_cnt_inc_s == rep_target_s);

    // Two-flop synchronizer on the raw button, running on every clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1_r <= 1'b0;
            sync_2_r <= 1'b0;
        end else begin
            sync_1_r <= btn_in;
            sync_2_r <= sync_1_r;
        end
    end

    // Next-state, counter and pulse computation; only CE edges advance.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        rep_cnt_s   = rep_cnt_r;
        rep_armed_s = rep_armed_r;
        btn_out_s   = btn_out_r;
        rise_s      = 1'b0;
        fall_s      = 1'b0;
        rep_s       = 1'b0;

        if (ce) begin
            // Auto-repeat advances on every CE while held; a pulse reloads it.
            if (held_s) begin
                if (rep_hit_s) begin
                    rep_cnt_s   = CNT_W'(0);
                    rep_armed_s = 1'b1;
                    rep_s       = 1'b1;
                end else begin
                    rep_cnt_s   = rep_cnt_inc_s;
                end
            end else begin
                rep_cnt_s   = CNT_W'(0);
                rep_armed_s = 1'b0;
            end

            case (state_r)
                ST_LOW: begin
                    if (sync_2_r) begin
                        if (SINGLE_C) begin
                            state_s     = ST_HIGH;
                            btn_out_s   = 1'b1;
                            rise_s      = 1'b1;
                            cnt_s       = CNT_W'(0);
                            rep_cnt_s   = CNT_W'(0);
                            rep_armed_s = 1'b0;
                        end else begin
                            state_s = ST_W_HIGH;
                            cnt_s   = CNT_W'(1);
                        end
                    end else begin
                        cnt_s = CNT_W'(0);
                    end
                end
                ST_W_HIGH: begin
                    if (!sync_2_r) begin
                        // Bounce: drop back without any strobe.
                        state_s = ST_LOW;
                        cnt_s   = CNT_W'(0);
                    end else if (stable_hit_s) begin
                        state_s     = ST_HIGH;
                        btn_out_s   = 1'b1;
                        rise_s      = 1'b1;
                        cnt_s       = CNT_W'(0);
                        rep_cnt_s   = CNT_W'(0);
                        rep_armed_s = 1'b0;
                    end else begin
                        cnt_s = cnt_inc_s;
                    end
                end
                ST_HIGH: begin
                    if (!sync_2_r) begin
                        if (SINGLE_C) begin
                            // Release accepted at once; FALL wins over REP.
                            state_s     = ST_LOW;
                            btn_out_s   = 1'b0;
                            fall_s      = 1'b1;
                            rep_s       = 1'b0;
                            cnt_s       = CNT_W'(0);
                            rep_cnt_s   = CNT_W'(0);
                            rep_armed_s = 1'b0;
                        end else begin
                            state_s = ST_W_LOW;
                            cnt_s   = CNT_W'(1);
                        end
                    end else begin
                        cnt_s = CNT_W'(0);
                    end
                end
                ST_W_LOW: begin
                    if (sync_2_r) begin
                        // Bounce: back to HIGH, repeat timing continues.
                        state_s = ST_HIGH;
                        cnt_s   = CNT_W'(0);
                    end else if (stable_hit_s) begin
                        // Release accepted; FALL wins over a coincident REP.
                        state_s     = ST_LOW;
                        btn_out_s   = 1'b0;
                        fall_s      = 1'b1;
                        rep_s       = 1'b0;
                        cnt_s       = CNT_W'(0);
                        rep_cnt_s   = CNT_W'(0);
                        rep_armed_s = 1'b0;
                    end else begin
                        cnt_s = cnt_inc_s;
                    end
                end
                default: begin
                    state_s     = ST_LOW;
                    btn_out_s   = 1'b0;
                    cnt_s       = CNT_W'(0);
                    rep_cnt_s   = CNT_W'(0);
                    rep_armed_s = 1'b0;
                end
            endcase
        end else begin
            // No strobe: hold everything, pulses stay low.
            state_s   = state_r;
            btn_out_s = btn_out_r;
        end
    end

    // State, counter and output registers; reset has priority over CE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_LOW;
            cnt_r       <= CNT_W'(0);
            rep_cnt_r   <= CNT_W'(0);
            rep_armed_r <= 1'b0;
            btn_out_r   <= 1'b0;
            rise_r      <= 1'b0;
            fall_r      <= 1'b0;
            rep_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            rep_cnt_r   <= rep_cnt_s;
            rep_armed_r <= rep_armed_s;
            btn_out_r   <= btn_out_s;
            rise_r      <= rise_s;
            fall_r      <= fall_s;
            rep_r       <= rep_s;
        end
    end

    assign btn_out  = btn_out_r;
    assign btn_rise = rise_r;
    assign btn_fall = fall_r;
    assign btn_rep  = rep_r;

endmodule

// File: tb/tb_ce_debounce.sv
// tb_ce_debounce: checks ce_debounce against a sample-history model.
// Instance A: N_STABLE=4, REPEAT_DLY=8, REPEAT_PER=3, CE every 5 clocks.
// Instance B: N_STABLE=1, auto-repeat off, CE on every clock.
module tb_ce_debounce;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, ce_a, btn_a, out_a, rise_a, fall_a, rep_a;
    logic rst_b, ce_b, btn_b, out_b, rise_b, fall_b, rep_b;
    bit   ce_rand = 1'b0;
    bit   chk_en  = 1'b0;
    bit   b_go    = 1'b0;
    bit   done    = 1'b0;

    int total = 0;
    int bad   = 0;

    ce_debounce #(.N_STABLE(4), .REPEAT_DLY(8), .REPEAT_PER(3), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst_a), .ce(ce_a), .btn_in(btn_a),
        .btn_out(out_a), .btn_rise(rise_a), .btn_fall(fall_a), .btn_rep(rep_a));

    ce_debounce #(.N_STABLE(1), .REPEAT_DLY(0), .REPEAT_PER(1), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst_b), .ce(ce_b), .btn_in(btn_b),
        .btn_out(out_b), .btn_rise(rise_b), .btn_fall(fall_b), .btn_rep(rep_b));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the level flips once the last n CE samples of the
    // synchronized input all differ from it; k counts CE ticks since the
    // accepted press and repeat pulses fire at k = dly, dly+per, ...
    typedef struct {
        logic        s1, s2, out, rise, fall, rep;
        int          k;
        logic [31:0] hist;
    } mstate_t;

    function automatic mstate_t mstep(input mstate_t m, input logic rst, input logic ce,
                                      input logic bin, input int n, input int dly, input int per);
        mstate_t r;
        bit      all_diff;
        r      = m;
        r.rise = 1'b0;
        r.fall = 1'b0;
        r.rep  = 1'b0;
        if (rst) begin
            r.s1 = 1'b0; r.s2 = 1'b0; r.out = 1'b0; r.k = 0; r.hist = '0;
            return r;
        end
        r.s1 = bin;
        r.s2 = m.s1;
        if (ce) begin
            r.hist   = {m.hist[30:0], m.s2};
            all_diff = 1'b1;
            for (int i = 0; i < n; i++) begin
                if (r.hist[i] == m.out) all_diff = 1'b0;
            end
            if (all_diff) begin
                r.out = ~m.out;
                r.k   = 0;
                if (r.out) r.rise = 1'b1;
                else       r.fall = 1'b1;
            end else if (m.out) begin
                r.k = m.k + 1;
                if (dly > 0 && r.k >= dly && ((r.k - dly) % per) == 0) r.rep = 1'b1;
            end
        end
        return r;
    endfunction

    mstate_t ma, mb;

    // Advance both models on every clock edge.
    always @(posedge clk) begin
        ma <= mstep(ma, rst_a, ce_a, btn_a, 4, 8, 3);
        mb <= mstep(mb, rst_b, ce_b, btn_b, 1, 0, 1);
    end

    // Compare every output of both instances on every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("a_out",  out_a,  ma.out);
            check("a_rise", rise_a, ma.rise);
            check("a_fall", fall_a, ma.fall);
            check("a_rep",  rep_a,  ma.rep);
            check("b_out",  out_b,  mb.out);
            check("b_rise", rise_b, mb.rise);
            check("b_fall", fall_b, mb.fall);
            check("b_rep",  rep_b,  mb.rep);
        end
    end

    // CE generator for instance A: one strobe every 5 clocks, or random.
    initial begin
        int div;
        div  = 0;
        ce_a = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ce_rand) begin
                ce_a = ($urandom_range(0, 2) == 0);
            end else begin
                ce_a = (div == 4);
                div  = (div == 4) ? 0 : div + 1;
            end
        end
    end

    // Return just after a CE edge of instance A.
    task automatic align();
        int guard;
        guard = 0;
        @(negedge clk);
        while (ce_a !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
    endtask

    task automatic run_for(input int cycles, output int nr, output int nf, output int np);
        nr = 0; nf = 0; np = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            nr += int'(rise_a); nf += int'(fall_a); np += int'(rep_a);
        end
    endtask

    task automatic run_until(input bit want_fall, input int limit, output int n,
                             output int nr, output int nf, output int np);
        n = 0; nr = 0; nf = 0; np = 0;
        do begin
            @(negedge clk);
            n++;
            nr += int'(rise_a); nf += int'(fall_a); np += int'(rep_a);
        end while (n < limit && !(want_fall ? fall_a : rise_a));
    endtask

    // Instance B: random input, output must follow it three falling edges later.
    initial begin
        logic h0, h1, h2;
        int   valid;
        btn_b = 1'b0;
        h0 = 1'b0; h1 = 1'b0; h2 = 1'b0;
        valid = 0;
        wait (b_go);
        while (!done) begin
            @(negedge clk);
            if (valid >= 3) check("b_follow", out_b, h2);
            h2 = h1;
            h1 = h0;
            if ($urandom_range(0, 2) == 0) h0 = ~h0;
            btn_b = h0;
            valid++;
        end
    end

    // Watchdog: the run must never hang.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Main directed and random sequence for instance A.
    initial begin
        int n, nr, nf, np, hold;
        rst_a = 1'b1; rst_b = 1'b1; btn_a = 1'b0; ce_b = 1'b1;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_out",  out_a,  0);
        check("rst_rise", rise_a, 0);
        check("rst_fall", fall_a, 0);
        check("rst_rep",  rep_a,  0);
        rst_a = 1'b0; rst_b = 1'b0; b_go = 1'b1;
        repeat (10) @(negedge clk);

        // Clean press: 2 sync clocks, first sample 3 clocks later, 3 more CE.
        align();
        btn_a = 1'b1;
        run_until(1'b0, 200, n, nr, nf, np);
        check("press_latency", n, 20);
        check("press_rises", nr, 1);
        check("press_falls", nf, 0);
        check("press_reps", np, 0);
        // Hold 20 CE ticks: repeats at ticks 8, 11, 14, 17, 20.
        run_for(100, nr, nf, np);
        check("hold_reps", np, 5);
        check("hold_rises", nr, 0);
        check("hold_falls", nf, 0);
        check("hold_out", out_a, 1);
        // Release right after tick 20: tick 23 still repeats while in W_LOW,
        // tick 24 accepts the release.
        btn_a = 1'b0;
        run_until(1'b1, 200, n, nr, nf, np);
        check("release_latency", n, 20);
        check("release_falls", nf, 1);
        check("release_reps", np, 1);
        run_for(60, nr, nf, np);
        check("after_release_pulses", nr + nf + np, 0);
        check("after_release_out", out_a, 0);

        // Bounce: 3 high samples, 1 low, then 4 high needed.
        align();
        btn_a = 1'b1;
        run_for(15, nr, nf, np);
        check("bounce_early_rise", nr, 0);
        btn_a = 1'b0;
        run_for(5, nr, nf, np);
        check("bounce_low_rise", nr, 0);
        btn_a = 1'b1;
        run_until(1'b0, 200, n, nr, nf, np);
        check("bounce_latency", n, 20);
        check("bounce_rises", nr, 1);
        btn_a = 1'b0;
        run_until(1'b1, 200, n, nr, nf, np);
        check("bounce_fall_latency", n, 20);
        run_for(20, nr, nf, np);

        // Glitch between strobes: two clocks high, no CE sees it.
        align();
        btn_a = 1'b1;
        @(negedge clk);
        @(negedge clk);
        btn_a = 1'b0;
        run_for(40, nr, nf, np);
        check("glitch_pulses", nr + nf + np, 0);
        check("glitch_out", out_a, 0);

        // Reset in W_HIGH after 3 samples, button still held.
        align();
        btn_a = 1'b1;
        run_for(15, nr, nf, np);
        rst_a = 1'b1;
        @(negedge clk);
        check("mid_rst_out", out_a, 0);
        check("mid_rst_rise", rise_a, 0);
        rst_a = 1'b0;
        run_until(1'b0, 200, n, nr, nf, np);
        check("requalify_latency", n, 19);
        check("requalify_rises", nr, 1);
        run_for(7, nr, nf, np);
        // Reset while HIGH forces the level low on the next cycle.
        rst_a = 1'b1;
        @(negedge clk);
        check("rst_high_out", out_a, 0);
        rst_a = 1'b0;
        btn_a = 1'b0;
        run_for(40, nr, nf, np);
        check("rst_high_rises", nr, 0);

        // Random phase: random hold lengths, random CE spacing, rare resets.
        ce_rand = 1'b1;
        hold = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (hold == 0) begin
                btn_a = $urandom_range(0, 1);
                hold  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 80);
            end
            hold--;
            rst_a = ($urandom_range(0, 399) == 0);
        end
        rst_a   = 1'b0;
        ce_rand = 1'b0;
        done    = 1'b1;
        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ce_debounce.md
Name: ce_debounce

Overview:
- Consumer end of the clock-enable interface: samples one asynchronous push-button input only on CE strobes from the clock-enable generator (typ. one 1-CLK pulse per 1 ms).
- Produces a debounced level, single-cycle rise/fall strobes, and an auto-repeat strobe while the button is held.
- Sits between board button pins and control FSMs / counters running on the same CLK.

Parameters:
- N_STABLE, 20, consecutive CE samples of the new level required to accept a change (1..255).
- REPEAT_DLY, 500, CE ticks in HIGH before the first BTN_REP pulse; 0 disables auto-repeat.
- REPEAT_PER, 100, CE ticks between subsequent BTN_REP pulses (>=1).
- CNT_W, 16, width of the internal tick counters; must hold max(N_STABLE, REPEAT_DLY, REPEAT_PER).

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset, synchronous, active-high.
- CE  in  1  sample strobe, 1 CLK wide, arbitrary spacing (including every cycle).
- BTN_IN  in  1  raw asynchronous button level.
- BTN_OUT  out  1  debounced level.
- BTN_RISE  out  1  1-CLK pulse on accepted 0->1.
- BTN_FALL  out  1  1-CLK pulse on accepted 1->0.
- BTN_REP  out  1  1-CLK auto-repeat pulse while held.

Behaviour:
- One clock and one reset: CLK, RST (synchronous, active-high). All flops update only on posedge CLK.
- Reset: sync flops = 0, state = LOW, counters = 0, BTN_OUT = BTN_RISE = BTN_FALL = BTN_REP = 0. RST has priority over CE.
- Synchronizer: 2-FF chain on BTN_IN clocked every CLK, not CE-gated. s = second stage.
- The FSM advances only on edges where CE = 1. With CE = 0, state, counters and BTN_OUT hold, and all pulse outputs are 0.
- States (BTN_OUT = 0 in LOW/W_HIGH, 1 in HIGH/W_LOW):
  - LOW, on CE: if s = 1 then cnt = 1 and go to W_HIGH. If N_STABLE = 1, go directly to HIGH and pulse RISE.
  - W_HIGH, on CE: if s = 0 then cnt = 0, go to LOW, no pulse. Else if cnt+1 = N_STABLE then go to HIGH, BTN_OUT = 1, pulse RISE, clear cnt and rep counter. Else cnt++.
  - HIGH, on CE: if s = 0 then cnt = 1, go to W_LOW (or directly to LOW with a FALL pulse if N_STABLE = 1). Auto-repeat counter advances on every CE in HIGH.
  - W_LOW: mirror of W_HIGH. An accepted change goes to LOW, BTN_OUT = 0, FALL pulse. A bounce back to s = 1 returns to HIGH.
- Auto-repeat: counts CE ticks while in HIGH or W_LOW (it pauses neither on a bounce nor in W_LOW).
  - First BTN_REP when the count reaches REPEAT_DLY; then the count reloads and a pulse fires every REPEAT_PER ticks.
  - The counter clears on entry to HIGH from W_HIGH and on entry to LOW.
  - If a REP pulse and a FALL pulse fall on the same CE, FALL wins and REP is suppressed.
- Pulse timing: all outputs are registered. Each pulse is high for exactly the CLK cycle following the CE edge that caused it. Pulses never repeat without a new CE.
- Latency: BTN_IN change to BTN_OUT = 2 CLK (synchronizer) + N_STABLE CE ticks, plus alignment to the next CE.
- Counter saturation: cnt never exceeds N_STABLE. The repeat counter wraps only via reload; no overflow path exists.
- Mid-operation RST: forces LOW in the next cycle. A pulse in flight is dropped. A button held through reset must be re-qualified with N_STABLE samples before RISE.

Test Plan:
Bench parameters: N_STABLE=4, REPEAT_DLY=8, REPEAT_PER=3, CE every 5 CLK.
- Clean press: BTN_IN 0->1 held -> BTN_OUT=1 and one BTN_RISE exactly 4 CE ticks after s=1, no FALL/REP; release -> one BTN_FALL after 4 CE ticks.
- Bounce: BTN_IN high for 3 CE ticks, low for 1, then high -> no RISE until 4 further consecutive high samples; exactly one RISE total.
- Auto-repeat: hold 20 CE ticks after RISE -> BTN_REP at ticks 8, 11, 14, 17, 20 (5 pulses); release -> REP stops, one FALL.
- CE held at 1 every cycle with N_STABLE=1 -> BTN_OUT follows s with 1 CLK delay; each edge gives one RISE or FALL.
- Glitch between CE strobes: 2-CLK high glitch with no CE during it -> no state change, no pulses.
- RST asserted in W_HIGH with cnt=3 and BTN_IN held 1 -> all outputs 0 the next cycle; RISE only after 4 new CE samples.
